axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master_pkg.sv | 35 +++
 rtl/axi_burst_master_fifo.sv | 58 +++++
 rtl/axi_burst_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_master_pkg.sv
// Shared definitions for the AXI line-burst master: AXI field widths,
// transaction IDs per address region, burst encodings and the FSM states.
package axi_burst_master_pkg;

  localparam int unsigned ID_BITS   = 4;
  localparam int unsigned LEN_BITS  = 8;
  localparam int unsigned SIZE_BITS = 3;

  localparam logic [ID_BITS-1:0] ID_CPU2MEM = 4'd1;
  localparam logic [ID_BITS-1:0] ID_CPU2DMA = 4'd2;
  localparam logic [ID_BITS-1:0] ID_CPU2AES = 4'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RSP
  } state_e;

  // Region is addr[19:16]; unknown regions fall back to the memory ID.
  function automatic logic [ID_BITS-1:0] region_id(input logic [3:0] region);
    case (region)
      4'd1:    return ID_CPU2DMA;
      4'd2:    return ID_CPU2AES;
      default: return ID_CPU2MEM;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_master_fifo.sv
// Request queue: first-word-fall-through FIFO, DEPTH a power of two >= 2.
// Ports: push_i/data_i write (ignored when full), pop_i read (ignored when
// empty), data_o shows the head entry, full_o/empty_o status.
module axi_burst_master_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_burst_master.sv
// Line-granular AXI master. Requests (read or write of one LINE_W line) are
// queued in a REQ_DEPTH FIFO and executed one AXI burst at a time, strictly in
// order, each producing exactly one completion on the resp_* handshake.
// Ports: req_* request in, resp_* completion out, AW/W/B/AR/R AXI master.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned REQ_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [LINE_W-1:0]    req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_we_o,
  output logic                 resp_err_o,
  output logic [LINE_W-1:0]    resp_rdata_o,
  output logic [ID_BITS-1:0]   awid_o,
  output logic [ADDR_W-1:0]    awaddr_o,
  output logic [LEN_BITS-1:0]  awlen_o,
  output logic [SIZE_BITS-1:0] awsize_o,
  output logic [1:0]           awburst_o,
  output logic                 awvalid_o,
  input  logic                 awready_i,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [DATA_W/8-1:0]  wstrb_o,
  output logic                 wlast_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  input  logic [ID_BITS-1:0]   bid_i,
  input  logic [2:0]           bresp_i,
  input  logic                 bvalid_i,
  output logic                 bready_o,
  output logic [ID_BITS-1:0]   arid_o,
  output logic [ADDR_W-1:0]    araddr_o,
  output logic [LEN_BITS-1:0]  arlen_o,
  output logic [SIZE_BITS-1:0] arsize_o,
  output logic [1:0]           arburst_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  input  logic [ID_BITS-1:0]   rid_i,
  input  logic [DATA_W-1:0]    rdata_i,
  input  logic [2:0]           rresp_i,
  input  logic                 rlast_i,
  input  logic                 rvalid_i,
  output logic                 rready_o
);

  localparam int unsigned BEATS = LINE_W / DATA_W;
  localparam int unsigned CNT_W = $clog2(BEATS) + 1;
  localparam int unsigned ENT_W = 1 + ADDR_W + LINE_W;

  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]     BEATS_C   = CNT_W'(BEATS);
  localparam logic [LEN_BITS-1:0]  AXLEN     = LEN_BITS'(BEATS - 1);
  localparam logic [SIZE_BITS-1:0] AXSIZE    = SIZE_BITS'($clog2(DATA_W / 8));

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                err_q, err_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic [1:0]          burst_q, burst_d;
  logic                accept_en_q, accept_en_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]    fifo_wdata, fifo_rdata;
  logic [3:0]          head_region;
  logic                err_acc;

  // Holding ready low until the first clock after reset keeps every ready
  // output at 0 while rst_ni is asserted.
  assign req_ready_o = accept_en_q && !fifo_full;
  assign fifo_push   = req_valid_i && req_ready_o;
  assign fifo_wdata  = {req_we_i, req_addr_i, req_wdata_i};
  assign head_region = fifo_rdata[LINE_W+16 +: 4];

  axi_burst_master_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign resp_we_o    = we_q;
  assign resp_err_o   = err_q;
  assign resp_rdata_o = rdata_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    beat_d      = beat_q;
    err_d       = err_q;
    id_d        = id_q;
    burst_d     = burst_q;
    accept_en_d = 1'b1;
    err_acc     = err_q;
    fifo_pop    = 1'b0;

    awid_o       = '0;
    awaddr_o     = '0;
    awlen_o      = '0;
    awsize_o     = '0;
    awburst_o    = '0;
    awvalid_o    = 1'b0;
    wdata_o      = '0;
    wstrb_o      = '0;
    wlast_o      = 1'b0;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;
    arid_o       = '0;
    araddr_o     = '0;
    arlen_o      = '0;
    arsize_o     = '0;
    arburst_o    = '0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    resp_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop              = 1'b1;
          {we_d, addr_d, line_d} = fifo_rdata;
          id_d    = region_id(head_region);
          burst_d = (head_region == 4'd2) ? BURST_FIXED : BURST_INCR;
          beat_d  = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = fifo_rdata[ENT_W-1] ? ST_AW : ST_AR;
        end
      end
      ST_AW: begin
        awvalid_o = 1'b1;
        awid_o    = id_q;
        awaddr_o  = addr_q;
        awlen_o   = AXLEN;
        awsize_o  = AXSIZE;
        awburst_o = burst_q;
        if (awready_i) state_d = ST_W;
      end
      ST_W: begin
        wvalid_o = 1'b1;
        wdata_o  = line_q[int'(beat_q)*DATA_W +: DATA_W];
        wstrb_o  = '1;
        wlast_o  = (beat_q == LAST_BEAT);
        if (wready_i) begin
          if (beat_q == LAST_BEAT) state_d = ST_B;
          else                     beat_d  = beat_q + CNT_W'(1);
        end
      end
      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          err_d   = err_q | (bresp_i != '0) | (bid_i != id_q);
          state_d = ST_RSP;
        end
      end
      ST_AR: begin
        arvalid_o = 1'b1;
        arid_o    = id_q;
        araddr_o  = addr_q;
        arlen_o   = AXLEN;
        arsize_o  = AXSIZE;
        arburst_o = burst_q;
        if (arready_i) state_d = ST_R;
      end
      ST_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          err_acc = err_q | (rresp_i != '0) | (rid_i != id_q);
          if (beat_q < BEATS_C) rdata_d[int'(beat_q)*DATA_W +: DATA_W] = rdata_i;
          if (rlast_i) begin
            if (beat_q != LAST_BEAT) err_acc = 1'b1;
            state_d = ST_RSP;
          end else begin
            // Missing rlast on the final beat is an error; the counter
            // saturates so surplus beats are dropped until rlast shows up.
            if (beat_q >= LAST_BEAT) err_acc = 1'b1;
            if (beat_q < BEATS_C)    beat_d  = beat_q + CNT_W'(1);
          end
          err_d = err_acc;
        end
      end
      ST_RSP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      id_q        <= '0;
      burst_q     <= '0;
      accept_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      id_q        <= id_d;
      burst_q     <= burst_d;
      accept_en_q <= accept_en_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a scripted AXI slave.
`timescale 1ns/1ps
module tb_axi_burst_master;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LINE_W    = 128;
  localparam int unsigned REQ_DEPTH = 4;

  localparam logic [3:0] EXP_ID_MEM = 4'd1;
  localparam logic [3:0] EXP_ID_DMA = 4'd2;
  localparam logic [3:0] EXP_ID_AES = 4'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_we_i = 1'b0;
  logic [31:0]  req_addr_i = '0;
  logic [127:0] req_wdata_i = '0;
  logic         resp_valid_o, resp_we_o, resp_err_o;
  logic         resp_ready_i = 1'b0;
  logic [127:0] resp_rdata_o;
  logic [3:0]   awid_o, arid_o;
  logic [31:0]  awaddr_o, araddr_o;
  logic [7:0]   awlen_o, arlen_o;
  logic [2:0]   awsize_o, arsize_o;
  logic [1:0]   awburst_o, arburst_o;
  logic         awvalid_o, arvalid_o;
  logic         awready_i = 1'b0, arready_i = 1'b0;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb_o;
  logic         wlast_o, wvalid_o;
  logic         wready_i = 1'b0;
  logic [3:0]   bid_i = '0;
  logic [2:0]   bresp_i = '0;
  logic         bvalid_i = 1'b0, bready_o;
  logic [3:0]   rid_i = '0;
  logic [31:0]  rdata_i = '0;
  logic [2:0]   rresp_i = '0;
  logic         rlast_i = 1'b0, rvalid_i = 1'b0, rready_o;

  axi_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .REQ_DEPTH(REQ_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_we_o(resp_we_o),
    .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  // slave configuration (written by the stimulus process)
  logic        aw_rdy_en = 1'b1;
  logic        w_toggle = 1'b0;
  logic [2:0]  b_resp_cfg = '0;
  logic [31:0] r_data [8];
  logic [2:0]  r_resp [8];
  logic        r_last [8];
  int unsigned r_n = 0;

  // slave observations (written by the slave process)
  logic [31:0]  aw_addr_q[$];
  logic [31:0]  w_q[$];
  logic         rsp_we_q[$];
  logic         rsp_err_q[$];
  logic [127:0] rsp_data_q[$];
  int unsigned  resp_cnt = 0, wlast_cnt = 0, wlast_pos = 0;
  int unsigned  stall_cnt = 0, stall_viol = 0;
  logic [3:0]   aw_id_l = '0, ar_id_l = '0, cur_awid = '0, cur_arid = '0, last_wstrb = '0;
  logic [7:0]   aw_len_l = '0, ar_len_l = '0;
  logic [2:0]   aw_size_l = '0, ar_size_l = '0;
  logic [1:0]   aw_burst_l = '0, ar_burst_l = '0;
  logic [31:0]  ar_addr_l = '0;
  longint       aw_rise_t = 0, ar_rise_t = 0;
  int unsigned  r_idx = 0;
  logic         r_act = 1'b0;

  // handshakes that will complete at the next posedge, with their payloads
  logic p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0, p_rsp = 0;
  logic [31:0]  s_awaddr = '0, s_araddr = '0, s_wdata = '0, prev_wdata = '0;
  logic [3:0]   s_awid = '0, s_arid = '0, s_wstrb = '0;
  logic [7:0]   s_awlen = '0, s_arlen = '0;
  logic [2:0]   s_awsize = '0, s_arsize = '0;
  logic [1:0]   s_awburst = '0, s_arburst = '0;
  logic         s_wlast = 0, s_rspwe = 0, s_rsperr = 0;
  logic [127:0] s_rspdata = '0;
  logic         prev_wstall = 0, prev_awvalid = 0, prev_arvalid = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; p_rsp = 0;
      awready_i = 0; arready_i = 0; wready_i = 0; bvalid_i = 0;
      rvalid_i = 0; rlast_i = 0; resp_ready_i = 0; r_act = 0;
      prev_wstall = 0; prev_awvalid = 0; prev_arvalid = 0;
    end else begin
      if (p_b) bvalid_i = 0;
      if (p_w) begin
        w_q.push_back(s_wdata);
        last_wstrb = s_wstrb;
        if (s_wlast) begin
          wlast_cnt++;
          wlast_pos = w_q.size();
          bvalid_i = 1; bid_i = cur_awid; bresp_i = b_resp_cfg;
        end
      end
      if (p_aw) begin
        aw_addr_q.push_back(s_awaddr);
        cur_awid = s_awid; aw_id_l = s_awid; aw_len_l = s_awlen;
        aw_size_l = s_awsize; aw_burst_l = s_awburst;
      end
      if (p_ar) begin
        cur_arid = s_arid; ar_id_l = s_arid; ar_len_l = s_arlen;
        ar_size_l = s_arsize; ar_burst_l = s_arburst; ar_addr_l = s_araddr;
        r_idx = 0; r_act = 1;
      end
      if (p_r) r_idx++;
      if (p_rsp) begin
        rsp_we_q.push_back(s_rspwe); rsp_err_q.push_back(s_rsperr);
        rsp_data_q.push_back(s_rspdata); resp_cnt++;
      end

      awready_i = aw_rdy_en;
      arready_i = 1;
      wready_i = w_toggle ? ~wready_i : 1'b1;
      resp_ready_i = 1;
      if (r_act && r_idx < r_n) begin
        rvalid_i = 1; rdata_i = r_data[r_idx]; rresp_i = r_resp[r_idx];
        rlast_i = r_last[r_idx]; rid_i = cur_arid;
      end else begin
        rvalid_i = 0; rlast_i = 0; r_act = 0;
      end

      if (prev_wstall && (!wvalid_o || wdata_o != prev_wdata)) stall_viol++;
      prev_wstall = wvalid_o && !wready_i;
      prev_wdata = wdata_o;
      if (prev_wstall) stall_cnt++;
      if (awvalid_o && !prev_awvalid) aw_rise_t = $time;
      if (arvalid_o && !prev_arvalid) ar_rise_t = $time;
      prev_awvalid = awvalid_o;
      prev_arvalid = arvalid_o;

      p_aw = awvalid_o && awready_i;
      s_awaddr = awaddr_o; s_awid = awid_o; s_awlen = awlen_o;
      s_awsize = awsize_o; s_awburst = awburst_o;
      p_w = wvalid_o && wready_i;
      s_wdata = wdata_o; s_wlast = wlast_o; s_wstrb = wstrb_o;
      p_b = bvalid_i && bready_o;
      p_ar = arvalid_o && arready_i;
      s_araddr = araddr_o; s_arid = arid_o; s_arlen = arlen_o;
      s_arsize = arsize_o; s_arburst = arburst_o;
      p_r = rvalid_i && rready_o;
      p_rsp = resp_valid_o && resp_ready_i;
      s_rspwe = resp_we_o; s_rsperr = resp_err_o; s_rspdata = resp_rdata_o;
    end
  end

  int unsigned n_chk = 0, n_bad = 0;
  longint acc_t = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [127:0] line);
    int unsigned k = 0;
    req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = line;
    while (!req_ready_o && k < 300) begin tick(); k++; end
    if (!req_ready_o) check("req_accept_timeout", 0, 1);
    acc_t = $time;
    tick();
  endtask

  task automatic wait_resp(input int unsigned n, input string tag);
    int unsigned k = 0;
    while (resp_cnt < n && k < 400) begin tick(); k++; end
    check({tag, "_resp_cnt"}, resp_cnt, n);
  endtask

  task automatic load_r(input int unsigned n, input int unsigned last_at,
                        input int unsigned bad_at, input logic [2:0] bad_resp);
    for (int i = 0; i < 8; i++) begin
      r_data[i] = 32'hC0DE_0000 | 32'(i);
      r_resp[i] = (i == int'(bad_at)) ? bad_resp : 3'd0;
      r_last[i] = (i == int'(last_at));
    end
    r_n = n;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rb, ab, wb, wlb, sb, vb, acc, k;
    logic [31:0] exp_w [4];

    // ---- reset values
    tick(); tick(); tick();
    check("rst_req_ready", req_ready_o, 0);
    check("rst_awvalid", awvalid_o, 0);
    check("rst_arvalid", arvalid_o, 0);
    check("rst_wvalid", wvalid_o, 0);
    check("rst_wlast", wlast_o, 0);
    check("rst_bready", bready_o, 0);
    check("rst_rready", rready_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_err", resp_err_o, 0);
    check("rst_resp_rdata", resp_rdata_o, 0);
    check("rst_awaddr", awaddr_o, 0);
    check("rst_awlen", awlen_o, 0);
    check("rst_arlen", arlen_o, 0);
    @(negedge clk); #2 rst_n = 1;
    tick(); tick();

    // ---- write line to region 0, ready slaves
    ab = aw_addr_q.size(); wb = w_q.size(); wlb = wlast_cnt; rb = resp_cnt;
    send_req(1, 32'h0000_0100, 128'h00000044_00000033_00000022_00000011);
    req_valid_i = 0;
    wait_resp(rb + 1, "wr");
    check("wr_latency", 128'((aw_rise_t + 1 - acc_t) / 10), 2);
    check("wr_aw_cnt", aw_addr_q.size() - ab, 1);
    check("wr_awaddr", aw_addr_q[ab], 32'h100);
    check("wr_awid", aw_id_l, EXP_ID_MEM);
    check("wr_awlen", aw_len_l, 3);
    check("wr_awsize", aw_size_l, 2);
    check("wr_awburst", aw_burst_l, 1);
    check("wr_beats", w_q.size() - wb, 4);
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) check($sformatf("wr_beat%0d", i), w_q[wb + i], exp_w[i]);
    check("wr_wlast_cnt", wlast_cnt - wlb, 1);
    check("wr_wlast_pos", wlast_pos, wb + 4);
    check("wr_wstrb", last_wstrb, 4'hF);
    check("wr_resp_we", rsp_we_q[rb], 1);
    check("wr_resp_err", rsp_err_q[rb], 0);
    check("wr_resp_rdata", rsp_data_q[rb], 0);

    // ---- read line from region 1
    load_r(4, 3, 99, 0);
    r_data[0] = 32'hAAAA_0001; r_data[1] = 32'hBBBB_0002;
    r_data[2] = 32'hCCCC_0003; r_data[3] = 32'hDDDD_0004;
    rb = resp_cnt;
    send_req(0, 32'h0001_0040, '0);
    req_valid_i = 0;
    wait_resp(rb + 1, "rd");
    check("rd_latency", 128'((ar_rise_t + 1 - acc_t) / 10), 2);
    check("rd_araddr", ar_addr_l, 32'h0001_0040);
    check("rd_arid", ar_id_l, EXP_ID_DMA);
    check("rd_arlen", ar_len_l, 3);
    check("rd_arsize", ar_size_l, 2);
    check("rd_arburst", ar_burst_l, 1);
    check("rd_resp_we", rsp_we_q[rb], 0);
    check("rd_resp_err", rsp_err_q[rb], 0);
    check("rd_resp_rdata", rsp_data_q[rb], 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);

    // ---- read with early rlast (3rd beat)
    load_r(3, 2, 99, 0);
    rb = resp_cnt; ab = aw_addr_q.size();
    send_req(0, 32'h0000_0300, '0);
    req_valid_i = 0;
    wait_resp(rb + 1, "early");
    check("early_err", rsp_err_q[rb], 1);
    for (int i = 0; i < 10; i++) tick();
    check("early_single_resp", resp_cnt, rb + 1);
    check("idle_no_aw", aw_addr_q.size(), ab);

    // ---- read with rresp=2 on beat 1
    load_r(4, 3, 1, 3'd2);
    rb = resp_cnt;
    send_req(0, 32'h0000_0340, '0);
    req_valid_i = 0;
    wait_resp(rb + 1, "rresp");
    check("rresp_err", rsp_err_q[rb], 1);
    for (int i = 0; i < 6; i++) tick();
    check("rresp_single_resp", resp_cnt, rb + 1);

    // ---- read with two surplus beats before rlast
    load_r(6, 5, 99, 0);
    rb = resp_cnt;
    send_req(0, 32'h0000_0380, '0);
    req_valid_i = 0;
    wait_resp(rb + 1, "extra");
    check("extra_err", rsp_err_q[rb], 1);
    check("extra_rdata", rsp_data_q[rb], 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);

    // ---- write with SLVERR on B
    b_resp_cfg = 3'd2;
    rb = resp_cnt;
    send_req(1, 32'h0000_0400, {4{32'h0BAD_0BAD}});
    req_valid_i = 0;
    wait_resp(rb + 1, "bresp");
    check("bresp_err", rsp_err_q[rb], 1);
    check("bresp_we", rsp_we_q[rb], 1);
    b_resp_cfg = 3'd0;

    // ---- back-to-back pushes with AW stalled
    aw_rdy_en = 0;
    tick();
    rb = resp_cnt; ab = aw_addr_q.size(); acc = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid_i = 1; req_we_i = 1;
      req_addr_i = 32'h0000_1000 * (acc + 1);
      req_wdata_i = {4{32'h5000_0000 + acc}};
      if (req_ready_o) acc++;
      tick();
    end
    check("fill_accepted", acc, 5);
    check("fill_ready_low", req_ready_o, 0);
    req_valid_i = 0;
    aw_rdy_en = 1;
    wait_resp(rb + 5, "fill");
    for (int i = 0; i < 10; i++) tick();
    check("fill_aw_cnt", aw_addr_q.size() - ab, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_order%0d", i), aw_addr_q[ab + i], 32'h1000 * (i + 1));
      check($sformatf("fill_err%0d", i), rsp_err_q[rb + i], 0);
    end

    // ---- region 2 write with wready toggling
    w_toggle = 1;
    rb = resp_cnt; wb = w_q.size(); sb = stall_cnt; vb = stall_viol;
    send_req(1, 32'h0002_0080, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    req_valid_i = 0;
    wait_resp(rb + 1, "aes");
    w_toggle = 0;
    check("aes_awburst", aw_burst_l, 0);
    check("aes_awid", aw_id_l, EXP_ID_AES);
    check("aes_beats", w_q.size() - wb, 4);
    exp_w = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    for (int i = 0; i < 4; i++) check($sformatf("aes_beat%0d", i), w_q[wb + i], exp_w[i]);
    check("aes_wlast_pos", wlast_pos, wb + 4);
    check("aes_stalled", 128'(stall_cnt > sb), 1);
    check("aes_stall_stable", stall_viol - vb, 0);
    check("aes_err", rsp_err_q[rb], 0);

    // ---- reset during R phase
    load_r(4, 3, 99, 0);
    rb = resp_cnt;
    send_req(0, 32'h0000_0200, '0);
    req_valid_i = 0;
    k = 0;
    while (!(rready_o && r_idx >= 1) && k < 100) begin tick(); k++; end
    check("rst_mid_in_r", rready_o, 1);
    #1 rst_n = 0;
    #1;
    check("rst_mid_rready", rready_o, 0);
    check("rst_mid_resp_valid", resp_valid_o, 0);
    check("rst_mid_arvalid", arvalid_o, 0);
    check("rst_mid_resp_rdata", resp_rdata_o, 0);
    tick(); tick();
    @(negedge clk); #2 rst_n = 1;
    tick(); tick();
    check("rst_mid_no_resp", resp_cnt, rb);
    wb = w_q.size();
    send_req(1, 32'h0000_0500, 128'h44444444_33333333_22222222_11111111);
    req_valid_i = 0;
    wait_resp(rb + 1, "post");
    check("post_we", rsp_we_q[rb], 1);
    check("post_err", rsp_err_q[rb], 0);
    check("post_beat3", w_q[wb + 3], 32'h44444444);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
